// File: rtl/uart_vram_loader_if.sv
// UART byte stream and VRAM port A signals seen by the loader.
// The loader drives through master; the UART/VRAM side uses slave.
interface uart_vram_loader_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic [ADDR_W-1:0] vram_addr;
  logic [7:0]        vram_di;
  logic              vram_we;
  logic              busy;
  logic              overrun;
  logic              timeout;

  modport master (
    input  rx_data, rx_done, tx_done,
    output tx_data, tx_wr, vram_addr, vram_di, vram_we, busy, overrun, timeout
  );

  modport slave (
    output rx_data, rx_done, tx_done,
    input  tx_data, tx_wr, vram_addr, vram_di, vram_we, busy, overrun, timeout
  );
endinterface

// File: rtl/uart_vram_loader.sv
// Command-driven UART-to-VRAM loader: 'A' sets the address, 'W' writes a block,
// 'C' returns and clears the running checksum. Every accepted byte is echoed.
module uart_vram_loader #(
  parameter int unsigned ADDR_W         = 14,
  parameter int unsigned TIMEOUT_CYCLES = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  uart_vram_loader_if.master bus
);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR_LO,
    S_ADDR_HI,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       count_q;
  logic [7:0]        checksum_q;
  logic [TW-1:0]     tcnt_q;
  logic [1:0]        rx_hist_q;
  logic              tx_pending_q;
  logic [7:0]        tx_data_q;
  logic              tx_wr_q;
  logic [7:0]        vram_di_q;
  logic              vram_we_q;
  logic              overrun_q;
  logic              timeout_q;

  logic              drop_d;
  logic              accept_d;
  logic [7:0]        echo_d;
  logic              tmo_hit_d;
  logic [15:0]       len_d;

  always_comb begin
    drop_d    = bus.rx_done && (rx_hist_q != 2'b00);
    accept_d  = bus.rx_done && (rx_hist_q == 2'b00);
    echo_d    = ((state_q == S_IDLE) && (bus.rx_data == 8'h43)) ? checksum_q : bus.rx_data;
    tmo_hit_d = (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    len_d     = {bus.rx_data, count_q[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      count_q      <= '0;
      checksum_q   <= '0;
      tcnt_q       <= '0;
      rx_hist_q    <= '0;
      tx_pending_q <= 1'b0;
      tx_data_q    <= '0;
      tx_wr_q      <= 1'b0;
      vram_di_q    <= '0;
      vram_we_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      rx_hist_q <= {rx_hist_q[0], bus.rx_done};
      tx_wr_q   <= 1'b0;
      vram_we_q <= 1'b0;
      // Address advances the cycle after the strobe so the write sees the old value.
      if (vram_we_q) addr_q <= addr_q + ADDR_W'(1);
      if (bus.tx_done) tx_pending_q <= 1'b0;
      if (drop_d) overrun_q <= 1'b1;

      if (accept_d) begin
        tcnt_q <= '0;
        if (tx_pending_q) begin
          overrun_q <= 1'b1;
        end else begin
          tx_wr_q      <= 1'b1;
          tx_data_q    <= echo_d;
          tx_pending_q <= 1'b1;
        end

        case (state_q)
          S_IDLE: begin
            if (bus.rx_data == 8'h41) state_q <= S_ADDR_LO;
            else if (bus.rx_data == 8'h57) state_q <= S_LEN_LO;
            else if (bus.rx_data == 8'h43) checksum_q <= '0;
          end
          S_ADDR_LO: begin
            addr_q[7:0] <= bus.rx_data;
            state_q     <= S_ADDR_HI;
          end
          S_ADDR_HI: begin
            addr_q[ADDR_W-1:8] <= bus.rx_data[ADDR_W-9:0];
            state_q            <= S_IDLE;
          end
          S_LEN_LO: begin
            count_q[7:0] <= bus.rx_data;
            state_q      <= S_LEN_HI;
          end
          S_LEN_HI: begin
            count_q[15:8] <= bus.rx_data;
            state_q       <= (len_d == 16'd0) ? S_IDLE : S_DATA;
          end
          S_DATA: begin
            vram_we_q  <= 1'b1;
            vram_di_q  <= bus.rx_data;
            checksum_q <= checksum_q + bus.rx_data;
            count_q    <= count_q - 16'd1;
            if (count_q == 16'd1) state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (state_q == S_IDLE) begin
        tcnt_q <= '0;
      end else if (tmo_hit_d) begin
        state_q   <= S_IDLE;
        timeout_q <= 1'b1;
        count_q   <= '0;
        tcnt_q    <= '0;
      end else begin
        tcnt_q <= tcnt_q + TW'(1);
      end
    end
  end

  assign bus.tx_data   = tx_data_q;
  assign bus.tx_wr     = tx_wr_q;
  assign bus.vram_addr = addr_q;
  assign bus.vram_di   = vram_di_q;
  assign bus.vram_we   = vram_we_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.overrun   = overrun_q;
  assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_uart_vram_loader.sv
// Bench for uart_vram_loader: a byte-level protocol model predicts every output
// each cycle; directed command sequences are also pinned to literal results.
module tb_uart_vram_loader;
  localparam int unsigned AW   = 14;
  localparam int unsigned TMO  = 100;
  localparam int          MASK = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_vram_loader_if #(.ADDR_W(AW)) bus ();

  uart_vram_loader #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(string name, int got, int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endfunction

  // ---------------- protocol model ----------------
  longint cyc     = 0;
  longint last_rx = -100;
  int  m_phase;   // 0 idle, 1 addr lo, 2 addr hi, 3 len lo, 4 len hi, 5 data
  int  m_addr, m_cnt, m_ck, m_quiet, b, echo;
  bit  m_pend, m_bump, acc, was_pend;
  int  e_tx_data, e_di;
  bit  e_tx_wr, e_we, e_ovr, e_to;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_addr = 0; m_cnt = 0; m_ck = 0; m_quiet = 0;
      m_pend = 0; m_bump = 0; last_rx = -100;
      e_tx_wr = 0; e_tx_data = 0; e_we = 0; e_di = 0; e_ovr = 0; e_to = 0;
    end else begin
      e_tx_wr  = 0;
      e_we     = 0;
      was_pend = m_pend;
      if (m_bump) begin m_addr = (m_addr + 1) & MASK; m_bump = 0; end
      if (bus.tx_done) m_pend = 0;
      acc = 0;
      if (bus.rx_done) begin
        if (cyc - last_rx <= 2) e_ovr = 1;
        else acc = 1;
        last_rx = cyc;
      end
      if (acc) begin
        b = int'(bus.rx_data);
        echo = b;
        m_quiet = 0;
        case (m_phase)
          0: if (b == 'h41) m_phase = 1;
             else if (b == 'h57) m_phase = 3;
             else if (b == 'h43) begin echo = m_ck; m_ck = 0; end
          1: begin m_addr = (m_addr & ~'hFF) | b; m_phase = 2; end
          2: begin m_addr = (m_addr & 'hFF) | ((b << 8) & MASK); m_phase = 0; end
          3: begin m_cnt = b; m_phase = 4; end
          4: begin m_cnt = m_cnt + b * 256; m_phase = (m_cnt == 0) ? 0 : 5; end
          default: begin
            e_we = 1; e_di = b; m_bump = 1;
            m_ck = (m_ck + b) % 256;
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_phase = 0;
          end
        endcase
        if (was_pend) e_ovr = 1;
        else begin e_tx_wr = 1; e_tx_data = echo; m_pend = 1; end
      end else if (m_phase == 0) begin
        m_quiet = 0;
      end else begin
        m_quiet++;
        if (m_quiet == TMO) begin m_phase = 0; e_to = 1; m_cnt = 0; m_quiet = 0; end
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare and logs ----------------
  int wlog[$];
  int elog[$];

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("tx_wr",     int'(bus.tx_wr),     int'(e_tx_wr));
      check("tx_data",   int'(bus.tx_data),   e_tx_data);
      check("vram_we",   int'(bus.vram_we),   int'(e_we));
      check("vram_di",   int'(bus.vram_di),   e_di);
      check("vram_addr", int'(bus.vram_addr), m_addr);
      check("busy",      int'(bus.busy),      int'(m_phase != 0));
      check("overrun",   int'(bus.overrun),   int'(e_ovr));
      check("timeout",   int'(bus.timeout),   int'(e_to));
      if (rst) begin
        wlog.delete();
        elog.delete();
      end else begin
        if (bus.vram_we) wlog.push_back((int'(bus.vram_addr) << 8) | int'(bus.vram_di));
        if (bus.tx_wr) elog.push_back(int'(bus.tx_data));
      end
    end
  end

  // ---------------- transmitter stand-in ----------------
  bit auto_ack = 1'b1;
  initial begin
    int owed;
    int wait_c;
    owed = 0;
    wait_c = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.tx_done = 1'b0;
      if (bus.tx_wr) owed = 1;
      if (owed != 0 && auto_ack) begin
        wait_c++;
        if (wait_c == 3) begin bus.tx_done = 1'b1; owed = 0; wait_c = 0; end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v);
    tick();
    bus.rx_data = v; bus.rx_done = 1'b1;
    tick();
    bus.rx_done = 1'b0;
    tick(7);
  endtask

  task automatic send_seq(input logic [7:0] s[]);
    foreach (s[i]) send_byte(s[i]);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] t1[] = '{8'h41, 8'h00, 8'h12, 8'h57, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    bus.rx_data = '0;
    bus.rx_done = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_addr", int'(bus.vram_addr), 0);
    check("rst_txwr", int'(bus.tx_wr), 0);

    // 1: address set and short block
    send_seq(t1);
    check("t1_nwr", wlog.size(), 3);
    check("t1_wr0", wlog[0], 'h1200AA);
    check("t1_wr1", wlog[1], 'h1201BB);
    check("t1_wr2", wlog[2], 'h1202CC);
    check("t1_necho", elog.size(), 9);
    foreach (t1[i]) check("t1_echo", elog[i], int'(t1[i]));
    check("t1_addr", int'(bus.vram_addr), 'h1203);
    check("t1_model_addr", m_addr, 'h1203);
    check("t1_busy", int'(bus.busy), 0);

    // 2: wrap plus checksum
    do_reset();
    send_seq('{8'h41, 8'hFF, 8'hFF, 8'h57, 8'h02, 8'h00, 8'h10, 8'h20});
    check("t2_model_ck", m_ck, 'h30);
    send_byte(8'h43);
    send_byte(8'h43);
    check("t2_nwr", wlog.size(), 2);
    check("t2_wr0", wlog[0], 'h3FFF10);
    check("t2_wr1", wlog[1], 'h000020);
    check("t2_necho", elog.size(), 10);
    check("t2_ck", elog[8], 'h30);
    check("t2_ck0", elog[9], 'h00);

    // 3: zero length and unknown byte
    do_reset();
    send_seq('{8'h57, 8'h00, 8'h00});
    check("t3_busy", int'(bus.busy), 0);
    send_byte(8'h99);
    check("t3_nwr", wlog.size(), 0);
    check("t3_necho", elog.size(), 4);
    check("t3_echo", elog[3], 'h99);

    // 4a: back-to-back rx_done drops the second byte
    do_reset();
    check("t4_ovr0", int'(bus.overrun), 0);
    tick();
    bus.rx_data = 8'h55; bus.rx_done = 1'b1;
    tick();
    bus.rx_data = 8'h66;
    tick();
    bus.rx_done = 1'b0;
    tick(8);
    check("t4a_necho", elog.size(), 1);
    check("t4a_echo", elog[0], 'h55);
    check("t4a_ovr", int'(bus.overrun), 1);

    // 4b: echo still pending when a data byte arrives
    do_reset();
    send_seq('{8'h57, 8'h02, 8'h00});
    auto_ack = 1'b0;
    send_byte(8'h01);
    send_byte(8'h02);
    auto_ack = 1'b1;
    tick(6);
    check("t4b_nwr", wlog.size(), 2);
    check("t4b_wr1", wlog[1], 'h000102);
    check("t4b_necho", elog.size(), 4);
    check("t4b_ovr", int'(bus.overrun), 1);

    // 5: inter-byte timeout
    do_reset();
    send_seq('{8'h57, 8'h05, 8'h00, 8'h11});
    check("t5_busy_mid", int'(bus.busy), 1);
    tick(100);
    check("t5_to", int'(bus.timeout), 1);
    check("t5_model_to", int'(e_to), 1);
    check("t5_busy", int'(bus.busy), 0);
    send_byte(8'h22);
    check("t5_nwr", wlog.size(), 1);
    check("t5_necho", elog.size(), 5);
    check("t5_echo", elog[4], 'h22);

    // 6: reset in the middle of a block
    do_reset();
    send_seq('{8'h57, 8'h04, 8'h00, 8'h01});
    do_reset();
    @(negedge clk);
    check("t6_busy", int'(bus.busy), 0);
    check("t6_addr", int'(bus.vram_addr), 0);
    check("t6_we", int'(bus.vram_we), 0);
    check("t6_di", int'(bus.vram_di), 0);
    send_seq('{8'h02, 8'h03, 8'h43});
    check("t6_nwr", wlog.size(), 0);
    check("t6_necho", elog.size(), 3);
    check("t6_ck", elog[2], 'h00);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_vram_loader.md
Name: uart_vram_loader

Overview:
Command-driven loader that sits between the uart receive/transmit interface and VRAM port A (the uart side).
- Parses a small byte protocol: set address, write block, read checksum.
- Writes VRAM one byte per received data byte.
- Echoes every received byte back as an ACK.
- Supervises link errors: overrun and inter-byte timeout.

Parameters:
ADDR_W, 14, VRAM address width; address wraps modulo 2^ADDR_W.
TIMEOUT_CYCLES, 25000000, max clk cycles between bytes inside a command before abort.

Ports:
clk  in  1  system clock (same clock as the VRAM port A clock).
rst  in  1  synchronous active-high reset.
rx_data  in  8  received byte; valid in the cycle rx_done is high.
rx_done  in  1  one-cycle pulse, new byte received.
tx_data  out  8  byte to transmit.
tx_wr  out  1  one-cycle pulse, start transmission of tx_data.
tx_done  in  1  one-cycle pulse, transmission finished.
vram_addr  out  ADDR_W  VRAM write address.
vram_di  out  8  VRAM write data.
vram_we  out  1  one-cycle write strobe.
busy  out  1  high whenever state != S_IDLE.
overrun  out  1  sticky: a byte was dropped or an echo was lost.
timeout  out  1  sticky: a command was aborted by the inter-byte timeout.

Behaviour:
Reset (rst sampled high on a clk edge):
- All outputs are 0; state = S_IDLE; checksum = 0; count = 0; tx_pending = 0; timeout counter = 0.
- Reset mid-command discards the command with no further VRAM writes.

Byte acceptance:
- A byte is accepted on a clk edge where rx_done = 1.
- If rx_done was also high 1 or 2 cycles earlier, the byte is dropped: no state change, no echo, overrun <= 1.

Echo:
- Cycle after acceptance: tx_wr = 1 and tx_data = echo byte. The echo byte is the received byte, except for the 'C' command (see below).
- tx_pending sets with tx_wr and clears on tx_done.
- If tx_pending is still set when a new byte is accepted: the byte is still processed, the echo is suppressed, overrun <= 1.
- tx_done while tx_pending = 0 is ignored.

States and transitions (each transition happens on an accepted byte):
- S_IDLE:
  - 0x41 'A' -> S_ADDR_LO.
  - 0x57 'W' -> S_LEN_LO.
  - 0x43 'C' -> stays in S_IDLE; echo byte = checksum instead of 0x43; checksum <= 0 on the same edge.
  - Any other byte is echoed and ignored.
- S_ADDR_LO: addr[7:0] <= byte -> S_ADDR_HI.
- S_ADDR_HI: addr[ADDR_W-1:8] <= byte[ADDR_W-9:0]; upper bits of byte are ignored -> S_IDLE.
- S_LEN_LO: count[7:0] <= byte -> S_LEN_HI.
- S_LEN_HI: count[15:8] <= byte.
  - Resulting count = 0 -> S_IDLE; no writes.
  - Otherwise -> S_DATA.
- S_DATA:
  - Cycle N (byte accepted).
  - Cycle N+1: vram_we = 1, vram_addr = current addr, vram_di = byte.
  - Cycle N+2: vram_we = 0, vram_addr = addr+1 mod 2^ADDR_W.
  - checksum <= checksum + byte mod 256.
  - count decrements; on reaching 0 -> S_IDLE.

Address behaviour:
- vram_addr always reflects the internal address register.
- Address wraps from 0x3FFF to 0x0000 with no error.

Timeout:
- Counter clears on every accepted byte and whenever state = S_IDLE.
- It increments each cycle in any other state.
- At TIMEOUT_CYCLES: state <= S_IDLE, timeout <= 1, count <= 0. The address register keeps its value.

Sticky flags:
- overrun and timeout clear only on rst.

Test Plan:
1. Address set and short block: rst; send 41 00 12 57 03 00 AA BB CC -> writes (0x1200,AA), (0x1201,BB), (0x1202,CC), each vram_we exactly 1 cycle; 9 tx_wr echoes equal to the sent bytes; busy low after the last byte; vram_addr = 0x1203.
2. Wrap plus checksum: send 41 FF FF (addr = 0x3FFF), then 57 02 00 10 20 -> writes at 0x3FFF then 0x0000; then 43 -> echo 0x30; send 43 again -> echo 0x00.
3. Zero length and unknown byte: send 57 00 00 -> no vram_we, busy low after the 3rd byte; send 99 -> echoed, state S_IDLE, no write.
4. Overrun cases:
   - rx_done on 2 consecutive cycles -> second byte dropped, overrun = 1.
   - tx_done withheld during a data byte -> that byte is written but its echo is suppressed, overrun = 1.
5. Timeout: TIMEOUT_CYCLES = 100; send 57 05 00 11 then idle 100 cycles -> busy falls, timeout = 1; next 0x22 is treated as an idle byte (echoed, not written).
6. Mid-command reset: rst asserted during S_DATA after 1 of 4 bytes -> all outputs 0 next cycle; subsequent data bytes produce no vram_we; checksum reads 0x00 via 43.
